// File: rtl/axi4lite_host_bridge.sv
// Single-request valid/ready port to AXI4-Lite host bridge, one transaction in flight.
// Define AXI_HOST_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES with RSP_RESP=2'b11.
module axi4lite_host_bridge #(
    parameter int AXI_AWIDTH     = 32,
    parameter int AXI_DWIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,

    input  logic                    REQ_VALID,
    output logic                    REQ_READY,
    input  logic                    REQ_WE,
    input  logic [AXI_AWIDTH-1:0]   REQ_ADDR,
    input  logic [AXI_DWIDTH-1:0]   REQ_WDATA,
    input  logic [AXI_DWIDTH/8-1:0] REQ_WSTRB,

    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [AXI_DWIDTH-1:0]   RSP_RDATA,
    output logic [1:0]              RSP_RESP,
    output logic                    BUSY,

    output logic [AXI_AWIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [AXI_DWIDTH-1:0]   M_AXI_WDATA,
    output logic [AXI_DWIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [AXI_AWIDTH-1:0]   M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [AXI_DWIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int STRB_W = AXI_DWIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_t;

    state_t                  state_q, state_d;
    logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DWIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [AXI_DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic                    req_ready_q, req_ready_d;
    logic                    busy_q;
    logic                    accept;
    logic                    timeout;

    assign accept = (state_q == IDLE) && REQ_VALID && req_ready_q;

`ifdef AXI_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer_q;
    logic          axi_phase;

    assign axi_phase = state_q inside {WR_AW_W, WR_B, RD_AR, RD_R};
    assign timeout   = axi_phase && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            timer_q <= '0;
        end else if (accept) begin
            timer_q <= '0;
        end else if (axi_phase) begin
            timer_q <= timer_q + 1'b1;
        end
    end
`else
    // The timeout parameter has no effect in this build.
    logic timeout_param_unused;
    assign timeout_param_unused = (TIMEOUT_CYCLES > 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            req_ready_q <= req_ready_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    // Every output is computed one cycle ahead here and then registered.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = REQ_ADDR;
                    wdata_d = REQ_WDATA;
                    wstrb_d = REQ_WSTRB;
                    if (REQ_WE) begin
                        state_d   = WR_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_AW_W: begin
                // AW and W retire independently; a dropped VALID marks its channel done.
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                end
            end
            WR_B: begin
                if (M_AXI_BVALID && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_AR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_R;
                end
            end
            RD_R: begin
                if (M_AXI_RVALID && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_resp_d  = 2'b11;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = RSP;
        end

        req_ready_d = (state_d == IDLE);
    end

    assign REQ_READY     = req_ready_q;
    assign RSP_VALID     = rsp_valid_q;
    assign RSP_RDATA     = rsp_rdata_q;
    assign RSP_RESP      = rsp_resp_q;
    assign BUSY          = busy_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4lite_host_bridge.sv
// Bench for axi4lite_host_bridge: delay-programmable AXI4-Lite responder plus a transaction-level expectation model.
// Build with AXI_HOST_TIMEOUT_EN defined to exercise the timeout abort.
`timescale 1ns/1ps
module tb_axi4lite_host_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_VALID, REQ_READY, REQ_WE;
    logic [AW-1:0] REQ_ADDR;
    logic [DW-1:0] REQ_WDATA;
    logic [SW-1:0] REQ_WSTRB;
    logic          RSP_VALID, RSP_READY;
    logic [DW-1:0] RSP_RDATA;
    logic [1:0]    RSP_RESP;
    logic          BUSY;
    logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [SW-1:0] M_AXI_WSTRB;
    logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
    logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic          M_AXI_RVALID, M_AXI_RREADY;

    always #5 CLK = ~CLK;

    axi4lite_host_bridge #(
        .AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_RESP(RSP_RESP), .BUSY(BUSY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    int vector_count    = 0;
    int miscompare_count = 0;

    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    bit          aw_stall = 1'b0, r_manual = 1'b0;
    logic [1:0]  b_resp_next = 2'b00, r_resp_next = 2'b00;
    logic [DW-1:0] r_data_next = '0;

    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    logic [AW-1:0] aw_addr_seen = '0, ar_addr_seen = '0;
    logic [DW-1:0] w_data_seen = '0;
    logic [SW-1:0] w_strb_seen = '0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Responder channels: each READY/VALID rises after its programmed delay once the bridge asks.
    initial begin : aw_responder
        int cnt;
        cnt = 0;
        M_AXI_AWREADY = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST || aw_stall || !M_AXI_AWVALID || M_AXI_AWREADY) begin
                M_AXI_AWREADY = 1'b0;
                cnt = 0;
            end else if (cnt >= aw_delay) M_AXI_AWREADY = 1'b1;
            else cnt++;
        end
    end

    initial begin : w_responder
        int cnt;
        cnt = 0;
        M_AXI_WREADY = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST || !M_AXI_WVALID || M_AXI_WREADY) begin
                M_AXI_WREADY = 1'b0;
                cnt = 0;
            end else if (cnt >= w_delay) M_AXI_WREADY = 1'b1;
            else cnt++;
        end
    end

    initial begin : ar_responder
        int cnt;
        cnt = 0;
        M_AXI_ARREADY = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST || !M_AXI_ARVALID || M_AXI_ARREADY) begin
                M_AXI_ARREADY = 1'b0;
                cnt = 0;
            end else if (cnt >= ar_delay) M_AXI_ARREADY = 1'b1;
            else cnt++;
        end
    end

    initial begin : b_responder
        int cnt;
        cnt = 0;
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP  = 2'b00;
        forever begin
            @(negedge CLK);
            if (RST) begin
                M_AXI_BVALID = 1'b0;
                cnt = 0;
            end else if (M_AXI_BVALID) begin
                if (!M_AXI_BREADY) M_AXI_BVALID = 1'b0;
            end else if (M_AXI_BREADY) begin
                if (cnt >= b_delay) begin
                    M_AXI_BVALID = 1'b1;
                    M_AXI_BRESP  = b_resp_next;
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    initial begin : r_responder
        int cnt;
        cnt = 0;
        M_AXI_RVALID = 1'b0;
        M_AXI_RRESP  = 2'b00;
        M_AXI_RDATA  = '0;
        forever begin
            @(negedge CLK);
            if (!r_manual) begin
                if (RST) begin
                    M_AXI_RVALID = 1'b0;
                    cnt = 0;
                end else if (M_AXI_RVALID) begin
                    if (!M_AXI_RREADY) M_AXI_RVALID = 1'b0;
                end else if (M_AXI_RREADY) begin
                    if (cnt >= r_delay) begin
                        M_AXI_RVALID = 1'b1;
                        M_AXI_RDATA  = r_data_next;
                        M_AXI_RRESP  = r_resp_next;
                        cnt = 0;
                    end else cnt++;
                end else cnt = 0;
            end
        end
    end

    initial begin : handshake_monitor
        forever begin
            @(posedge CLK);
            if (!RST) begin
                if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_hs++; aw_addr_seen = M_AXI_AWADDR; end
                if (M_AXI_WVALID && M_AXI_WREADY) begin
                    w_hs++;
                    w_data_seen = M_AXI_WDATA;
                    w_strb_seen = M_AXI_WSTRB;
                end
                if (M_AXI_BVALID && M_AXI_BREADY) b_hs++;
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin ar_hs++; ar_addr_seen = M_AXI_ARADDR; end
                if (M_AXI_RVALID && M_AXI_RREADY) r_hs++;
            end
        end
    end

    // One complete transaction; called on a negedge, returns on the negedge after the response is taken.
    task automatic applyStimulus(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic [SW-1:0] strb, input int d_aw, input int d_w, input int d_b,
                                 input int d_ar, input int d_r, input logic [1:0] resp,
                                 input logic [DW-1:0] rdata, input int hold);
        int aw0, w0, b0, ar0, r0, lat, exp_lat, waited;
        bit rr_ok, stable_ok, quiet_ok;
        logic [DW-1:0] exp_rdata;
        aw_delay = d_aw; w_delay = d_w; b_delay = d_b; ar_delay = d_ar; r_delay = d_r;
        b_resp_next = resp; r_resp_next = resp; r_data_next = rdata;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
        exp_rdata = we ? '0 : rdata;
        exp_lat   = we ? (((d_aw > d_w) ? d_aw : d_w) + 1 + d_b + 1 + 1) : (d_ar + 1 + d_r + 1 + 1);

        waited = 0;
        while (!REQ_READY && waited < 100) begin @(negedge CLK); waited++; end
        checkOutput("req_ready_before_accept", REQ_READY, 1'b1);
        REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wdata; REQ_WSTRB = strb;
        @(negedge CLK);
        REQ_VALID = 1'($urandom_range(0, 1)); REQ_WE = 1'($urandom_range(0, 1));
        REQ_ADDR = 32'($urandom); REQ_WDATA = 32'($urandom); REQ_WSTRB = 4'($urandom);
        checkOutput("busy_after_accept", BUSY, 1'b1);

        lat = 1;
        rr_ok = 1'b1;
        while (!RSP_VALID && lat < 200) begin
            if (REQ_READY) rr_ok = 1'b0;
            @(negedge CLK);
            lat++;
        end
        checkOutput("req_ready_low_in_flight", rr_ok, 1'b1);
        checkOutput("latency", lat, exp_lat);
        checkOutput("rsp_rdata", RSP_RDATA, exp_rdata);
        checkOutput("rsp_resp", RSP_RESP, resp);

        stable_ok = 1'b1;
        quiet_ok  = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            if (!RSP_VALID || RSP_RDATA !== exp_rdata || RSP_RESP !== resp) stable_ok = 1'b0;
            if (REQ_READY || M_AXI_ARVALID || M_AXI_AWVALID || M_AXI_WVALID) quiet_ok = 1'b0;
        end
        checkOutput("rsp_held_stable", stable_ok, 1'b1);
        checkOutput("quiet_while_holding", quiet_ok, 1'b1);

        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
        REQ_VALID = 1'b0;
        checkOutput("rsp_valid_dropped", RSP_VALID, 1'b0);
        checkOutput("req_ready_after_rsp", REQ_READY, 1'b1);
        checkOutput("busy_after_rsp", BUSY, 1'b0);

        checkOutput("aw_handshakes", aw_hs - aw0, we ? 1 : 0);
        checkOutput("w_handshakes",  w_hs - w0,   we ? 1 : 0);
        checkOutput("b_handshakes",  b_hs - b0,   we ? 1 : 0);
        checkOutput("ar_handshakes", ar_hs - ar0, we ? 0 : 1);
        checkOutput("r_handshakes",  r_hs - r0,   we ? 0 : 1);
        if (we) begin
            checkOutput("awaddr", aw_addr_seen, addr);
            checkOutput("wdata", w_data_seen, wdata);
            checkOutput("wstrb", w_strb_seen, strb);
        end else begin
            checkOutput("araddr", ar_addr_seen, addr);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int waited;
        bit ok;
        RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '0;
        RSP_READY = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("reset_req_ready", REQ_READY, 1'b0);
        checkOutput("reset_outputs",
                    {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, RSP_VALID, BUSY}, 7'b0);
        checkOutput("reset_rsp_fields", {RSP_RDATA, RSP_RESP}, '0);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("req_ready_after_release", REQ_READY, 1'b1);

        $display("[TB] directed transactions");
        applyStimulus(1'b1, 32'h4000_0000, 32'h0000_0041, 4'b0001, 0, 0, 0, 0, 0, 2'b00, 32'h1234_5678, 0);
        applyStimulus(1'b1, 32'h4000_0004, 32'hA5A5_0F0F, 4'b1100, 0, 3, 1, 0, 0, 2'b01, 32'h0, 1);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'b0000, 0, 0, 0, 2, 3, 2'b00, 32'hDEAD_BEEF, 0);
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, 4'b0000, 0, 0, 0, 1, 0, 2'b10, 32'hCAFE_F00D, 5);
        applyStimulus(1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'b0000, 2, 2, 0, 0, 0, 2'b11, 32'h0, 0);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom), 4'($urandom),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          2'($urandom), 32'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] reset during read data phase");
        ar_delay = 0; r_delay = 1000;
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 32'h0000_0100;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        waited = 0;
        while (!M_AXI_RREADY && waited < 20) begin @(negedge CLK); waited++; end
        checkOutput("rready_before_reset", M_AXI_RREADY, 1'b1);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("midreset_outputs",
                    {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, RSP_VALID, BUSY, REQ_READY},
                    8'b0);
        checkOutput("midreset_rsp_fields", {RSP_RDATA, RSP_RESP}, '0);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("req_ready_after_midreset", REQ_READY, 1'b1);
        r_manual = 1'b1;
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hBAD0_BAD0; M_AXI_RRESP = 2'b01;
        ok = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (RSP_VALID || BUSY) ok = 1'b0;
        end
        checkOutput("stray_rvalid_ignored", ok, 1'b1);
        M_AXI_RVALID = 1'b0;
        r_manual = 1'b0;
        @(negedge CLK);
        applyStimulus(1'b0, 32'h0000_0104, 32'h0, 4'b0000, 0, 0, 0, 1, 1, 2'b00, 32'h0BAD_F00D, 0);

        $display("[TB] stalled AW channel");
        aw_stall = 1'b1; w_delay = 0; b_delay = 0; b_resp_next = 2'b01;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 32'h0000_0200; REQ_WDATA = 32'h5555_AAAA; REQ_WSTRB = 4'hF;
        @(negedge CLK);
        REQ_VALID = 1'b0;
`ifdef AXI_HOST_TIMEOUT_EN
        repeat (TO - 1) @(negedge CLK);
        checkOutput("awvalid_before_timeout", M_AXI_AWVALID, 1'b1);
        checkOutput("rsp_valid_before_timeout", RSP_VALID, 1'b0);
        @(negedge CLK);
        checkOutput("valids_after_timeout", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b000);
        checkOutput("rsp_valid_on_timeout", RSP_VALID, 1'b1);
        checkOutput("rsp_resp_on_timeout", RSP_RESP, 2'b11);
        checkOutput("rsp_rdata_on_timeout", RSP_RDATA, 32'h0);
        aw_stall = 1'b0;
        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
        checkOutput("req_ready_after_timeout", REQ_READY, 1'b1);
        repeat (3) @(negedge CLK);
        checkOutput("idle_after_timeout", {M_AXI_AWVALID, M_AXI_BREADY, RSP_VALID, BUSY}, 4'b0000);
`else
        repeat (40) @(negedge CLK);
        checkOutput("awvalid_waits_forever", M_AXI_AWVALID, 1'b1);
        checkOutput("no_rsp_while_stalled", RSP_VALID, 1'b0);
        checkOutput("busy_while_stalled", BUSY, 1'b1);
        aw_stall = 1'b0;
        waited = 0;
        while (!RSP_VALID && waited < 20) begin @(negedge CLK); waited++; end
        checkOutput("rsp_after_stall", RSP_VALID, 1'b1);
        checkOutput("rsp_resp_after_stall", RSP_RESP, 2'b01);
        checkOutput("awaddr_after_stall", aw_addr_seen, 32'h0000_0200);
        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
        checkOutput("req_ready_after_stall", REQ_READY, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
